// File: rtl/uart_pkg.sv
// Shared UART timing constants and the TX arbiter state encoding.
// Default inter-frame gap is one bit time at the base clock and baud rate.
package uart_pkg;
  localparam int BASE_FREQ          = 50_000_000;
  localparam int BAUD_RATE          = 115_200;
  localparam int COUNTS_PER_BIT     = BASE_FREQ / BAUD_RATE;
  localparam int DEFAULT_GAP_CYCLES = COUNTS_PER_BIT;

  typedef enum logic [2:0] {
    IDLE,
    ACCEPT,
    LAUNCH,
    WAIT_DONE,
    GAP
  } arb_state_e;
endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request after i_ptr, wrapping.
// Shared by arbiters that keep their own pointer register.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);
  logic [IW-1:0] w_k;

  // Walk offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    o_idx = '0;
    o_any = 1'b0;
    w_k   = '0;
    for (int i = N; i >= 1; i--) begin
      w_k = IW'((int'(i_ptr) + i) % N);
      if (i_req[w_k]) begin
        o_idx = w_k;
        o_any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART TX core among NUM_REQ byte producers,
// with watchdog on frame completion, inter-frame gap and bounded burst locking.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int DATA_W         = 8,
  parameter int GAP_CYCLES     = DEFAULT_GAP_CYCLES,
  parameter int TIMEOUT_CYCLES = 8192,
  parameter int LOCK_MAX       = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  input  logic [NUM_REQ-1:0]         req_lock,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [DATA_W-1:0]          tx_data,
  output logic                       tx_start,
  input  logic                       tx_busy,
  input  logic                       tx_done,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       grant_active,
  output logic                       err_timeout
);
  localparam int IDW    = $clog2(NUM_REQ);
  localparam int WD_W   = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int GAP_W  = $clog2(GAP_CYCLES) + 1;
  localparam int LOCK_W = $clog2(LOCK_MAX) + 1;
  localparam logic [WD_W-1:0]   WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [LOCK_W-1:0] LOCK_LIM = LOCK_W'(LOCK_MAX);

  arb_state_e          r_state, w_nstate;
  logic [NUM_REQ-1:0]  r_req_ready, w_ready_n;
  logic [DATA_W-1:0]   r_tx_data, w_data_n;
  logic                r_tx_start, w_start_n;
  logic [IDW-1:0]      r_grant_id, w_gid_n;
  logic [IDW-1:0]      r_rr_ptr, w_ptr_n;
  logic [LOCK_W-1:0]   r_lock_cnt, w_lock_n;
  logic [WD_W-1:0]     r_wd_cnt, w_wd_n;
  logic [GAP_W-1:0]    r_gap_cnt, w_gap_n;
  logic                r_grant_active;
  logic                r_err_timeout, w_err_n;
  logic                w_frame_end;
  logic [IDW-1:0]      w_pick_idx;
  logic                w_pick_any;
  logic [NUM_REQ-1:0][DATA_W-1:0] w_req_bytes;

  assign w_req_bytes = req_data;

  rr_pick #(.N(NUM_REQ), .IW(IDW)) u_pick (
    .i_req (req_valid),
    .i_ptr (r_rr_ptr),
    .o_idx (w_pick_idx),
    .o_any (w_pick_any)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= IDLE;
      r_req_ready    <= '0;
      r_tx_data      <= '0;
      r_tx_start     <= 1'b0;
      r_grant_id     <= '0;
      r_rr_ptr       <= IDW'(NUM_REQ - 1);
      r_lock_cnt     <= '0;
      r_wd_cnt       <= '0;
      r_gap_cnt      <= '0;
      r_grant_active <= 1'b0;
      r_err_timeout  <= 1'b0;
    end else begin
      r_state        <= w_nstate;
      r_req_ready    <= w_ready_n;
      r_tx_data      <= w_data_n;
      r_tx_start     <= w_start_n;
      r_grant_id     <= w_gid_n;
      r_rr_ptr       <= w_ptr_n;
      r_lock_cnt     <= w_lock_n;
      r_wd_cnt       <= w_wd_n;
      r_gap_cnt      <= w_gap_n;
      r_grant_active <= (w_nstate != IDLE);
      r_err_timeout  <= w_err_n;
    end
  end

  // tx_start is registered, so the busy check happens one edge ahead of the pulse.
  always_comb begin
    w_nstate    = r_state;
    w_ready_n   = '0;
    w_start_n   = 1'b0;
    w_data_n    = r_tx_data;
    w_gid_n     = r_grant_id;
    w_ptr_n     = r_rr_ptr;
    w_lock_n    = r_lock_cnt;
    w_wd_n      = '0;
    w_gap_n     = '0;
    w_err_n     = r_err_timeout;
    w_frame_end = 1'b0;
    unique case (r_state)
      IDLE: if (w_pick_any) begin
        w_nstate              = ACCEPT;
        w_gid_n               = w_pick_idx;
        w_ready_n[w_pick_idx] = 1'b1;
        w_lock_n              = '0;
      end
      ACCEPT: if (req_valid[r_grant_id]) begin
        w_nstate  = LAUNCH;
        w_data_n  = w_req_bytes[r_grant_id];
        w_ptr_n   = r_grant_id;
        w_start_n = ~tx_busy;
        if (r_lock_cnt < LOCK_LIM) w_lock_n = r_lock_cnt + 1'b1;
      end else begin
        w_nstate = IDLE;
      end
      LAUNCH: if (r_tx_start) w_nstate = WAIT_DONE;
              else            w_start_n = ~tx_busy;
      WAIT_DONE: if (tx_done || r_wd_cnt == WD_LAST) begin
        w_err_n = r_err_timeout | ~tx_done;
        if (GAP_CYCLES == 0) w_frame_end = 1'b1;
        else                 w_nstate    = GAP;
      end else begin
        w_wd_n = r_wd_cnt + 1'b1;
      end
      GAP: if (r_gap_cnt == GAP_LAST) w_frame_end = 1'b1;
           else                       w_gap_n     = r_gap_cnt + 1'b1;
      default: w_nstate = IDLE;
    endcase
    if (w_frame_end) begin
      if (req_lock[r_grant_id] && req_valid[r_grant_id] && r_lock_cnt < LOCK_LIM) begin
        w_nstate              = ACCEPT;
        w_ready_n[r_grant_id] = 1'b1;
      end else begin
        w_nstate = IDLE;
      end
    end
  end

  assign req_ready    = r_req_ready;
  assign tx_data      = r_tx_data;
  assign tx_start     = r_tx_start;
  assign grant_id     = r_grant_id;
  assign grant_active = r_grant_active;
  assign err_timeout  = r_err_timeout;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: requester and TX-core models on negedge,
// hand-computed grant orders, latencies and watchdog boundaries.
module tb_uart_tx_arbiter;
  localparam int NR = 4, DW = 8, GAP = 4, TMO = 64, LMAX = 16;

  logic               clk = 1'b0;
  logic               rst;
  logic [NR-1:0]      req_valid, req_lock, req_ready;
  logic [NR*DW-1:0]   req_data;
  logic [DW-1:0]      tx_data;
  logic               tx_start, tx_busy, grant_active, err_timeout;
  logic               tx_done = 1'b0;
  logic [1:0]         grant_id;

  // main-owned stimulus
  int          added[NR];
  logic [DW-1:0] base[NR];
  logic        lock_en[NR];
  logic        busy_hold, done_en;
  int          done_dly;
  int          n_chk = 0, n_fail = 0;

  // model-owned state
  int          taken[NR] = '{default: 0};
  logic        pend[NR]  = '{default: 1'b0};
  logic        mbusy = 1'b0;
  int          cd = 0, ncyc = 0, n_start = 0, n_done = 0, n_multi = 0;
  int          last_done = -100000;
  logic [DW-1:0] done_data = '0;
  int          grant_log[$];
  int          gap_log[$];
  logic [DW-1:0] data_log[$];

  uart_tx_arbiter #(
    .NUM_REQ(NR), .DATA_W(DW), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO), .LOCK_MAX(LMAX)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_lock(req_lock),
    .req_ready(req_ready), .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .tx_done(tx_done), .grant_id(grant_id), .grant_active(grant_active), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  always_comb begin
    req_valid = '0;
    req_lock  = '0;
    req_data  = '0;
    for (int i = 0; i < NR; i++) begin
      req_valid[i]         = (added[i] != taken[i]);
      req_lock[i]          = lock_en[i];
      req_data[i*DW +: DW] = base[i] + DW'(taken[i]);
    end
  end

  assign tx_busy = mbusy | busy_hold;

  // Monitor, requester pops and TX core model, in a fixed order each negedge.
  always @(negedge clk) begin
    ncyc++;
    if (rst) begin
      cd = 0; mbusy = 1'b0; tx_done = 1'b0;
      for (int i = 0; i < NR; i++) pend[i] = 1'b0;
    end else begin
      if (tx_start) begin n_start++; data_log.push_back(tx_data); end
      if (req_ready != '0) begin
        grant_log.push_back(int'(grant_id));
        gap_log.push_back(ncyc - last_done);
        if (!$onehot(req_ready)) n_multi++;
      end
      if (tx_done) begin n_done++; last_done = ncyc; done_data = tx_data; end
      for (int i = 0; i < NR; i++) if (pend[i]) begin taken[i]++; pend[i] = 1'b0; end
      for (int i = 0; i < NR; i++) if (req_ready[i] && added[i] != taken[i]) pend[i] = 1'b1;
      tx_done = 1'b0;
      if (tx_start) begin
        if (done_en) begin mbusy = 1'b1; cd = done_dly; end
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) begin tx_done = 1'b1; mbusy = 1'b0; end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit pending();
    for (int i = 0; i < NR; i++) if (added[i] != taken[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic wait_idle(input string tag, input int bound);
    int t = 0;
    do begin @(negedge clk); t++; end while ((grant_active || pending()) && t < bound);
    chk({tag, "_idle"}, 32'(t < bound), 1);
  endtask

  initial begin
    int g0, s0, d0, t, mn, tk1, tk3;
    logic [DW-1:0] b1, b3;
    rst = 1'b1; busy_hold = 1'b0; done_en = 1'b1; done_dly = 30;
    for (int i = 0; i < NR; i++) begin added[i] = 0; base[i] = '0; lock_en[i] = 1'b0; end
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_start", 32'(tx_start), 0);
    chk("rst_data", 32'(tx_data), 0);
    chk("rst_gid", 32'(grant_id), 0);
    chk("rst_active", 32'(grant_active), 0);
    chk("rst_err", 32'(err_timeout), 0);
    rst = 1'b0;

    // round robin: all four with two bytes each, from reset pointer
    @(negedge clk);
    g0 = grant_log.size(); s0 = n_start; d0 = data_log.size();
    for (int i = 0; i < NR; i++) begin base[i] = DW'(8'h40 + 16 * i); added[i] += 2; end
    wait_idle("rr", 1000);
    chk("rr_count", grant_log.size() - g0, 8);
    if (grant_log.size() - g0 == 8)
      for (int k = 0; k < 8; k++) chk("rr_order", grant_log[g0 + k], k % 4);
    chk("rr_starts", n_start - s0, 8);
    chk("rr_data", 32'(data_log[d0 + 4]), 32'h41);
    mn = 1000;
    for (int k = g0; k < gap_log.size(); k++) if (gap_log[k] < mn) mn = gap_log[k];
    chk("rr_gap", 32'(mn >= 5), 1);

    // lock burst: req1 20 bytes locked, req3 one byte
    @(negedge clk);
    g0 = grant_log.size(); d0 = data_log.size();
    tk1 = taken[1]; tk3 = taken[3]; b1 = 8'h10; b3 = 8'h80;
    base[1] = b1; base[3] = b3; lock_en[1] = 1'b1; added[1] += 20; added[3] += 1;
    wait_idle("lock", 3000);
    lock_en[1] = 1'b0;
    chk("lock_count", grant_log.size() - g0, 21);
    if (grant_log.size() - g0 == 21)
      for (int k = 0; k < 21; k++) chk("lock_order", grant_log[g0 + k], (k == 16) ? 3 : 1);
    chk("lock_d15", 32'(data_log[d0 + 15]), 32'(DW'(b1 + DW'(tk1 + 15))));
    chk("lock_d16", 32'(data_log[d0 + 16]), 32'(DW'(b3 + DW'(tk3))));
    chk("lock_d20", 32'(data_log[d0 + 20]), 32'(DW'(b1 + DW'(tk1 + 19))));

    // single requester 2, data A5: ready at k+1, start at k+2
    @(negedge clk);
    s0 = n_start;
    base[2] = DW'(8'hA5 - DW'(taken[2])); added[2] += 1;
    @(negedge clk);
    chk("one_ready", 32'(req_ready), 32'b0100);
    chk("one_gid", 32'(grant_id), 2);
    chk("one_active", 32'(grant_active), 1);
    @(negedge clk);
    chk("one_start", 32'(tx_start), 1);
    chk("one_data", 32'(tx_data), 32'hA5);
    chk("one_ready_clr", 32'(req_ready), 0);
    wait_idle("one", 500);
    chk("one_done_data", 32'(done_data), 32'hA5);
    chk("one_starts", n_start - s0, 1);

    // tx_busy held 50 cycles across LAUNCH
    busy_hold = 1'b1;
    @(negedge clk);
    s0 = n_start; added[0] += 1; t = 0;
    repeat (50) begin @(negedge clk); if (tx_start) t++; end
    chk("busy_nostart", t, 0);
    chk("busy_active", 32'(grant_active), 1);
    busy_hold = 1'b0;
    @(negedge clk); chk("busy_start", 32'(tx_start), 1);
    @(negedge clk); chk("busy_pulse", 32'(tx_start), 0);
    wait_idle("busy", 500);
    chk("busy_starts", n_start - s0, 1);

    // watchdog: no tx_done
    done_en = 1'b0;
    @(negedge clk);
    added[2] += 1; t = 0;
    while (!tx_start && t < 20) begin @(negedge clk); t++; end
    chk("wd_start", 32'(tx_start), 1);
    t = 0;
    while (!err_timeout && t < 200) begin @(negedge clk); t++; end
    chk("wd_latency", 32'(t >= 64 && t <= 65), 1);
    done_en = 1'b1;
    wait_idle("wd", 500);
    chk("wd_sticky", 32'(err_timeout), 1);
    @(negedge clk);
    g0 = grant_log.size(); s0 = n_start; added[3] += 1;
    wait_idle("wd_next", 500);
    chk("wd_next_gid", (grant_log.size() > g0) ? grant_log[g0] : -1, 3);
    chk("wd_next_start", n_start - s0, 1);
    chk("wd_sticky2", 32'(err_timeout), 1);

    // asynchronous reset during WAIT_DONE
    @(negedge clk);
    base[2] = DW'(8'h5A - DW'(taken[2])); added[2] += 1; t = 0;
    while (!tx_start && t < 20) begin @(negedge clk); t++; end
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_ready", 32'(req_ready), 0);
    chk("arst_start", 32'(tx_start), 0);
    chk("arst_data", 32'(tx_data), 0);
    chk("arst_gid", 32'(grant_id), 0);
    chk("arst_active", 32'(grant_active), 0);
    chk("arst_err", 32'(err_timeout), 0);
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("arst_idle", 32'(grant_active), 0);
    g0 = grant_log.size();
    added[0] += 1; added[3] += 1;
    wait_idle("arst_rr", 500);
    chk("arst_first", (grant_log.size() > g0) ? grant_log[g0] : -1, 0);
    chk("arst_second", (grant_log.size() > g0 + 1) ? grant_log[g0 + 1] : -1, 3);

    // tx_done lands on the watchdog expiry cycle: counts as done
    done_dly = 64;
    @(negedge clk);
    d0 = n_done; added[1] += 1;
    wait_idle("exp", 500);
    chk("exp_done", n_done - d0, 1);
    chk("exp_no_err", 32'(err_timeout), 0);

    chk("ready_onehot", n_multi, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
